systolic_feeder: RTL and testbench

SYSTOLIC_FEEDER -- requirements
Module: systolic_feeder

---
 rtl/systolic_feeder_if.sv | 32 +++
 rtl/systolic_feeder.sv | 112 +++++++++++
 tb/tb_systolic_feeder.sv | 349 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/systolic_feeder_if.sv
// Operand-write / start bus and array-edge outputs of the systolic feeder.
// start is a one-cycle request honoured only while idle; busy covers the whole run and done marks its last cycle.
interface systolic_feeder_if #(
  parameter int SIZE = 4
);
  localparam int AW = (SIZE > 1) ? $clog2(SIZE) : 1;

  logic                  wr_en;
  logic                  wr_sel;
  logic [AW-1:0]         wr_row;
  logic [AW-1:0]         wr_col;
  logic [7:0]            wr_data;
  logic                  start;
  logic [SIZE-1:0][7:0]  a_out;
  logic [SIZE-1:0][7:0]  b_out;
  logic                  mult_en;
  logic                  acc_en;
  logic                  load_en;
  logic                  busy;
  logic                  done;
  logic [2:0]            dbg_state;

  modport master (
    output wr_en, wr_sel, wr_row, wr_col, wr_data, start,
    input  a_out, b_out, mult_en, acc_en, load_en, busy, done, dbg_state
  );

  modport slave (
    input  wr_en, wr_sel, wr_row, wr_col, wr_data, start,
    output a_out, b_out, mult_en, acc_en, load_en, busy, done, dbg_state
  );
endinterface

// File: rtl/systolic_feeder.sv
// Holds A/B operand matrices and streams them diagonally skewed into a SIZE x SIZE
// output-stationary MAC array, sequencing clear, feed, drain and done.
module systolic_feeder #(
  parameter int SIZE = 4
) (
  input  logic             clk,
  input  logic             reset,
  systolic_feeder_if.slave bus
);
  localparam int AW = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam int CW = $clog2(2 * SIZE);
  localparam logic [CW-1:0] LAST_FEED  = CW'(2 * SIZE - 2);
  localparam logic [CW-1:0] LAST_DRAIN = CW'((SIZE > 1) ? SIZE - 2 : 0);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_FEED  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t state, state_next;
  logic [CW-1:0] cnt, cnt_next;

  logic [SIZE-1:0][SIZE-1:0][7:0] a_mem;
  logic [SIZE-1:0][SIZE-1:0][7:0] b_mem;

  logic [SIZE-1:0][7:0] a_next, b_next;
  logic mac_next, load_next, busy_next, done_next;

  assign bus.dbg_state = state;

  // Operands are only writable while idle so a run always sees a stable matrix.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_mem <= '0;
      b_mem <= '0;
    end else if (bus.wr_en && state == S_IDLE) begin
      if (bus.wr_sel) b_mem[bus.wr_row][bus.wr_col] <= bus.wr_data;
      else            a_mem[bus.wr_row][bus.wr_col] <= bus.wr_data;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    unique case (state)
      S_IDLE:  if (bus.start) state_next = S_CLEAR;
      S_CLEAR: begin
        state_next = S_FEED;
        cnt_next   = '0;
      end
      S_FEED: begin
        if (cnt == LAST_FEED) begin
          state_next = (SIZE > 1) ? S_DRAIN : S_DONE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      S_DRAIN: begin
        if (cnt == LAST_DRAIN) state_next = S_DONE;
        else                   cnt_next   = cnt + CW'(1);
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Outputs are computed for the upcoming state/step and registered, so they line up with it.
  always_comb begin
    load_next = (state_next == S_CLEAR);
    mac_next  = (state_next == S_FEED) || (state_next == S_DRAIN);
    done_next = (state_next == S_DONE);
    busy_next = (state_next != S_IDLE);
    a_next    = '0;
    b_next    = '0;
    if (state_next == S_FEED) begin
      for (int k = 0; k < SIZE; k++) begin
        if (int'(cnt_next) >= k && int'(cnt_next) - k < SIZE) begin
          a_next[k] = a_mem[k][AW'(int'(cnt_next) - k)];
          b_next[k] = b_mem[AW'(int'(cnt_next) - k)][k];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      bus.a_out   <= '0;
      bus.b_out   <= '0;
      bus.mult_en <= 1'b0;
      bus.acc_en  <= 1'b0;
      bus.load_en <= 1'b0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      bus.a_out   <= a_next;
      bus.b_out   <= b_next;
      bus.mult_en <= mac_next;
      bus.acc_en  <= mac_next;
      bus.load_en <= load_next;
      bus.busy    <= busy_next;
      bus.done    <= done_next;
    end
  end
endmodule

// File: tb/tb_systolic_feeder.sv
// Randomized and directed bench for systolic_feeder: per-cycle edge traffic against a
// schedule derived from the skew rule, plus a behavioural MAC array checked against A x B.
module tb_systolic_feeder;
  localparam int SIZE = 4;
  localparam int RUN  = 3 * SIZE;
  localparam int W    = 5 + 16 * SIZE;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  systolic_feeder_if #(.SIZE(SIZE)) bus ();
  systolic_feeder #(.SIZE(SIZE)) dut (.clk(clk), .reset(reset), .bus(bus));

  int checks = 0;
  int errors = 0;

  logic [7:0]   ma [SIZE][SIZE];
  logic [7:0]   mb [SIZE][SIZE];
  logic [W-1:0] exp_q [$];
  logic [W-1:0] obs_q [$];
  logic [W-1:0] post_obs;

  // Behavioural output-stationary array fed by the DUT edges.
  logic [31:0] c_acc [SIZE][SIZE];
  logic [7:0]  ar [SIZE][SIZE];
  logic [7:0]  br [SIZE][SIZE];

  always @(negedge clk) begin
    for (int i = 0; i < SIZE; i++) begin
      for (int j = 0; j < SIZE; j++) begin
        logic [7:0] ai, bi;
        ai = (j == 0) ? bus.a_out[i] : ar[i][j-1];
        bi = (i == 0) ? bus.b_out[j] : br[i-1][j];
        if (bus.load_en) begin
          c_acc[i][j] <= '0;
          ar[i][j]    <= '0;
          br[i][j]    <= '0;
        end else if (bus.mult_en && bus.acc_en) begin
          c_acc[i][j] <= c_acc[i][j] + 32'(ai) * 32'(bi);
          ar[i][j]    <= ai;
          br[i][j]    <= bi;
        end
      end
    end
  end

  function automatic logic [W-1:0] pack_obs();
    return {bus.busy, bus.done, bus.load_en, bus.mult_en, bus.acc_en, bus.a_out, bus.b_out};
  endfunction

  function automatic logic [31:0] ref_c(input int i, input int j);
    logic [31:0] s = 0;
    for (int k = 0; k < SIZE; k++) s += 32'(ma[i][k]) * 32'(mb[k][j]);
    return s;
  endfunction

  task automatic build_exp();
    exp_q.delete();
    for (int c = 0; c < RUN; c++) begin
      logic [SIZE-1:0][7:0] ea, eb;
      logic mac;
      ea  = '0;
      eb  = '0;
      mac = (c >= 1) && (c <= RUN - 2);
      if (c >= 1 && c <= 2 * SIZE - 1) begin
        for (int k = 0; k < SIZE; k++) begin
          if (c - 1 - k >= 0 && c - 1 - k < SIZE) begin
            ea[k] = ma[k][c-1-k];
            eb[k] = mb[c-1-k][k];
          end
        end
      end
      exp_q.push_back({1'b1, c == RUN - 1, c == 0, mac, mac, ea, eb});
    end
  endtask

  task automatic write_elem(input bit sel, input int r, input int c, input logic [7:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_sel  = sel;
    bus.wr_row  = 2'(r);
    bus.wr_col  = 2'(c);
    bus.wr_data = d;
    @(negedge clk);
    bus.wr_en   = 1'b0;
  endtask

  task automatic write_all();
    for (int r = 0; r < SIZE; r++)
      for (int c = 0; c < SIZE; c++) begin
        write_elem(1'b0, r, c, ma[r][c]);
        write_elem(1'b1, r, c, mb[r][c]);
      end
  endtask

  task automatic set_ident_b();
    for (int r = 0; r < SIZE; r++)
      for (int c = 0; c < SIZE; c++) begin
        ma[r][c] = (r == c) ? 8'd1 : 8'd0;
        mb[r][c] = 8'(SIZE * r + c + 1);
      end
  endtask

  // Drives one run from the idle negedge; optional stray start/write and same-cycle write.
  task automatic run_capture(input int stray_start_c, input bit stray_wr, input bit same_wr);
    bus.start = 1'b1;
    if (same_wr) begin
      bus.wr_en = 1'b1; bus.wr_sel = 1'b0; bus.wr_row = 2'd1; bus.wr_col = 2'd1; bus.wr_data = 8'd5;
    end
    @(negedge clk);
    bus.start = 1'b0;
    bus.wr_en = 1'b0;
    obs_q.delete();
    for (int c = 0; c < RUN; c++) begin
      obs_q.push_back(pack_obs());
      bus.start = (c == stray_start_c);
      if (stray_wr && c >= 1 && c < 2 * SIZE) begin
        bus.wr_en = 1'b1; bus.wr_sel = 1'b0; bus.wr_row = 2'd0; bus.wr_col = 2'd0; bus.wr_data = 8'd9;
      end else begin
        bus.wr_en = 1'b0;
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    bus.wr_en = 1'b0;
    post_obs  = pack_obs();
    #1;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (pack_obs() !== '0 || bus.dbg_state !== 3'd0) begin
      errors++; $display("FAIL reset_hold got %h state %0d exp 0", pack_obs(), bus.dbg_state);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (pack_obs() !== '0) begin
      errors++; $display("FAIL reset_release got %h exp 0", pack_obs());
    end
    for (int r = 0; r < SIZE; r++) for (int c = 0; c < SIZE; c++) begin ma[r][c] = 0; mb[r][c] = 0; end
    build_exp();
    run_capture(-1, 1'b0, 1'b0);
    for (int c = 0; c < RUN; c++) begin
      logic [W-1:0] e = exp_q.pop_front();
      checks++;
      if (obs_q[c] !== e) begin errors++; $display("FAIL reset_zero_run c%0d got %h exp %h", c, obs_q[c], e); end
    end
  endtask

  task automatic test_identity();
    logic [SIZE-1:0][7:0] oa, ob;
    int mac_cnt;
    set_ident_b();
    write_all();
    build_exp();
    run_capture(-1, 1'b0, 1'b0);
    for (int c = 0; c < RUN; c++) begin
      logic [W-1:0] e = exp_q.pop_front();
      checks++;
      if (obs_q[c] !== e) begin errors++; $display("FAIL ident_cycle c%0d got %h exp %h", c, obs_q[c], e); end
    end
    checks++;
    if (obs_q[0][W-3] !== 1'b1) begin errors++; $display("FAIL ident_clear_load got %b exp 1", obs_q[0][W-3]); end
    oa = obs_q[1][16*SIZE-1:8*SIZE]; ob = obs_q[1][8*SIZE-1:0];
    checks++;
    if (oa !== 32'h00000001 || ob !== 32'h00000001) begin
      errors++; $display("FAIL ident_t0 got a %h b %h exp 00000001", oa, ob);
    end
    ob = obs_q[4][8*SIZE-1:0];
    checks++;
    if (ob !== 32'h04070A0D) begin errors++; $display("FAIL ident_t3_b got %h exp 04070a0d", ob); end
    oa = obs_q[7][16*SIZE-1:8*SIZE];
    checks++;
    if (oa !== 32'h01000000) begin errors++; $display("FAIL ident_t6_a got %h exp 01000000", oa); end
    mac_cnt = 0;
    for (int c = 0; c < RUN; c++) if (obs_q[c][W-4]) mac_cnt++;
    checks++;
    if (mac_cnt != 10 || post_obs[W-1] !== 1'b0) begin
      errors++; $display("FAIL ident_len mac %0d busy_after %b exp 10 0", mac_cnt, post_obs[W-1]);
    end
    for (int i = 0; i < SIZE; i++) for (int j = 0; j < SIZE; j++) begin
      checks++;
      if (c_acc[i][j] !== 32'(SIZE * i + j + 1)) begin
        errors++; $display("FAIL ident_c[%0d][%0d] got %0d exp %0d", i, j, c_acc[i][j], SIZE * i + j + 1);
      end
    end
  endtask

  task automatic test_ignore_busy();
    logic [SIZE-1:0][7:0] oa;
    build_exp();
    run_capture(3, 1'b1, 1'b0);
    for (int c = 0; c < RUN; c++) begin
      logic [W-1:0] e = exp_q.pop_front();
      checks++;
      if (obs_q[c] !== e) begin errors++; $display("FAIL ignore_cycle c%0d got %h exp %h", c, obs_q[c], e); end
    end
    checks++;
    if (post_obs !== '0 || bus.dbg_state !== 3'd0) begin
      errors++; $display("FAIL ignore_idle_after got %h state %0d exp 0", post_obs, bus.dbg_state);
    end
    build_exp();
    run_capture(-1, 1'b0, 1'b0);
    oa = obs_q[1][16*SIZE-1:8*SIZE];
    checks++;
    if (oa[0] !== 8'd1) begin errors++; $display("FAIL ignore_a00_kept got %0d exp 1", oa[0]); end
    for (int i = 0; i < SIZE; i++) for (int j = 0; j < SIZE; j++) begin
      checks++;
      if (c_acc[i][j] !== ref_c(i, j)) begin
        errors++; $display("FAIL ignore_c[%0d][%0d] got %0d exp %0d", i, j, c_acc[i][j], ref_c(i, j));
      end
    end
  endtask

  task automatic test_same_cycle_write();
    logic [SIZE-1:0][7:0] oa;
    ma[1][1] = 8'd5;
    build_exp();
    run_capture(-1, 1'b0, 1'b1);
    for (int c = 0; c < RUN; c++) begin
      logic [W-1:0] e = exp_q.pop_front();
      checks++;
      if (obs_q[c] !== e) begin errors++; $display("FAIL samewr_cycle c%0d got %h exp %h", c, obs_q[c], e); end
    end
    oa = obs_q[3][16*SIZE-1:8*SIZE];
    checks++;
    if (oa[1] !== 8'd5) begin errors++; $display("FAIL samewr_t2_a1 got %0d exp 5", oa[1]); end
  endtask

  task automatic test_async_reset();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checks++;
    if (pack_obs() !== '0 || bus.dbg_state !== 3'd0) begin
      errors++; $display("FAIL async_reset got %h state %0d exp 0", pack_obs(), bus.dbg_state);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    set_ident_b();
    write_all();
    build_exp();
    run_capture(-1, 1'b0, 1'b0);
    for (int c = 0; c < RUN; c++) begin
      logic [W-1:0] e = exp_q.pop_front();
      checks++;
      if (obs_q[c] !== e) begin errors++; $display("FAIL arst_cycle c%0d got %h exp %h", c, obs_q[c], e); end
    end
    for (int i = 0; i < SIZE; i++) for (int j = 0; j < SIZE; j++) begin
      checks++;
      if (c_acc[i][j] !== ref_c(i, j)) begin
        errors++; $display("FAIL arst_c[%0d][%0d] got %0d exp %0d", i, j, c_acc[i][j], ref_c(i, j));
      end
    end
  endtask

  task automatic test_all_ones();
    int mac_cnt, first, last;
    for (int r = 0; r < SIZE; r++) for (int c = 0; c < SIZE; c++) begin ma[r][c] = 1; mb[r][c] = 1; end
    write_all();
    build_exp();
    run_capture(-1, 1'b0, 1'b0);
    mac_cnt = 0; first = -1; last = -1;
    for (int c = 0; c < RUN; c++) begin
      logic [W-1:0] e = exp_q.pop_front();
      checks++;
      if (obs_q[c] !== e) begin errors++; $display("FAIL ones_cycle c%0d got %h exp %h", c, obs_q[c], e); end
      if (obs_q[c][W-4] && obs_q[c][W-5]) begin
        mac_cnt++; if (first < 0) first = c; last = c;
      end
    end
    checks++;
    if (mac_cnt != 10 || last - first != 9) begin
      errors++; $display("FAIL ones_mac_run got %0d span %0d exp 10 9", mac_cnt, last - first);
    end
    for (int i = 0; i < SIZE; i++) for (int j = 0; j < SIZE; j++) begin
      checks++;
      if (c_acc[i][j] !== 32'd4) begin errors++; $display("FAIL ones_c[%0d][%0d] got %0d exp 4", i, j, c_acc[i][j]); end
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 3; it++) begin
      for (int r = 0; r < SIZE; r++) for (int c = 0; c < SIZE; c++) begin
        ma[r][c] = 8'($urandom_range(0, 255));
        mb[r][c] = 8'($urandom_range(0, 255));
      end
      write_all();
      build_exp();
      run_capture(-1, 1'b0, 1'b0);
      for (int c = 0; c < RUN; c++) begin
        logic [W-1:0] e = exp_q.pop_front();
        checks++;
        if (obs_q[c] !== e) begin errors++; $display("FAIL rand%0d_cycle c%0d got %h exp %h", it, c, obs_q[c], e); end
      end
      for (int i = 0; i < SIZE; i++) for (int j = 0; j < SIZE; j++) begin
        checks++;
        if (c_acc[i][j] !== ref_c(i, j)) begin
          errors++; $display("FAIL rand%0d_c[%0d][%0d] got %0d exp %0d", it, i, j, c_acc[i][j], ref_c(i, j));
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int run = 0; run < 2; run++) begin
      build_exp();
      run_capture(-1, 1'b0, 1'b0);
      for (int c = 0; c < RUN; c++) begin
        logic [W-1:0] e = exp_q.pop_front();
        checks++;
        if (obs_q[c] !== e) begin errors++; $display("FAIL b2b%0d_cycle c%0d got %h exp %h", run, c, obs_q[c], e); end
      end
      for (int i = 0; i < SIZE; i++) for (int j = 0; j < SIZE; j++) begin
        checks++;
        if (c_acc[i][j] !== ref_c(i, j)) begin
          errors++; $display("FAIL b2b%0d_c[%0d][%0d] got %0d exp %0d", run, i, j, c_acc[i][j], ref_c(i, j));
        end
      end
    end
  endtask

  initial begin
    bus.wr_en = 1'b0; bus.wr_sel = 1'b0; bus.wr_row = '0; bus.wr_col = '0;
    bus.wr_data = '0; bus.start = 1'b0;
    test_reset();
    test_identity();
    test_ignore_busy();
    test_same_cycle_write();
    test_async_reset();
    test_all_ones();
    test_random();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout got running exp finished");
    $fatal(1, "watchdog");
  end
endmodule
